// File: rtl/core_host_seq_if.sv
// Bundled preload, core-control, memory and result-stream signals of the host sequencer.
// The master modport is the sequencer side; the slave modport is the memory/core/host side.
interface core_host_seq_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          core_req;
    logic          core_done;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_dat;
    logic [DW-1:0] mem_rd_dat;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;

    modport master (
        input  ld_valid, ld_data, core_done, mem_rd_dat, rd_ready,
        output ld_ready, core_req, mem_wr_en, mem_addr, mem_wr_dat, rd_valid, rd_data
    );

    modport slave (
        output ld_valid, ld_data, core_done, mem_rd_dat, rd_ready,
        input  ld_ready, core_req, mem_wr_en, mem_addr, mem_wr_dat, rd_valid, rd_data
    );
endinterface

// File: rtl/core_host_seq.sv
// Host sequencer: preload a data memory from a stream, kick the core, time its run,
// then drain result words from memory to an output stream.
module core_host_seq #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned LOAD_CNT  = 4,
    parameter int unsigned READ_BASE = 64,
    parameter int unsigned READ_CNT  = 2,
    parameter int unsigned TMO       = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    core_host_seq_if.master       bus,
    output logic                  busy,
    output logic                  fin,
    output logic                  timeout,
    output logic [31:0]           run_cycles
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StErr} state_e;

    state_e      state_q, state_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] run_q, run_d;
    logic        first_q, first_d;
    logic        timeout_q, timeout_d;
    logic        fin_q, fin_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            run_q     <= '0;
            first_q   <= 1'b0;
            timeout_q <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_q     <= run_d;
            first_q   <= first_d;
            timeout_q <= timeout_d;
            fin_q     <= fin_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_d     = run_q;
        first_d   = 1'b0;
        timeout_d = timeout_q;
        fin_d     = 1'b0;
        unique case (state_q)
            StIdle, StErr: begin
                if (start) begin
                    timeout_d = 1'b0;
                    run_d     = '0;
                    idx_d     = '0;
                    if (LOAD_CNT == 0) begin
                        state_d = StRun;
                        first_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (bus.ld_valid) begin
                    if (idx_q == LOAD_CNT - 1) begin
                        state_d = StRun;
                        idx_d   = '0;
                        first_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 32'd1;
                    end
                end
            end
            StRun: begin
                // The request cycle neither counts nor looks at core_done, which may be stale.
                if (!first_q) begin
                    run_d = run_q + 32'd1;
                    if (bus.core_done) begin
                        idx_d = '0;
                        if (READ_CNT == 0) begin
                            state_d = StIdle;
                            fin_d   = 1'b1;
                        end else begin
                            state_d = StDrain;
                        end
                    end else if (run_d >= TMO) begin
                        state_d   = StErr;
                        timeout_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (bus.rd_ready) begin
                    if (idx_q == READ_CNT - 1) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        fin_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 32'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from registered state only, so reset clears them without a clock.
    always_comb begin
        bus.ld_ready   = 1'b0;
        bus.core_req   = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_addr   = {AW{1'b0}};
        bus.mem_wr_dat = {DW{1'b0}};
        bus.rd_valid   = 1'b0;
        bus.rd_data    = {DW{1'b0}};
        unique case (state_q)
            StLoad: begin
                bus.ld_ready = 1'b1;
                bus.mem_addr = AW'(LOAD_BASE + idx_q);
                if (bus.ld_valid) begin
                    bus.mem_wr_en  = 1'b1;
                    bus.mem_wr_dat = bus.ld_data;
                end
            end
            StRun: bus.core_req = first_q;
            StDrain: begin
                bus.rd_valid = 1'b1;
                bus.mem_addr = AW'(READ_BASE + idx_q);
                bus.rd_data  = bus.mem_rd_dat;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != StIdle);
    assign fin        = fin_q;
    assign timeout    = timeout_q;
    assign run_cycles = run_q;

endmodule

// File: tb/tb_core_host_seq.sv
// Directed-random bench for core_host_seq: wrapping preload, stale/late/never core_done,
// stalled drain, ERR recovery and asynchronous reset in the middle of a run.
module tb_core_host_seq;

    localparam int unsigned LB    = 254;
    localparam int unsigned RB    = 64;
    localparam int unsigned TMO_P = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start;
    logic        busy, fin, timeout;
    logic [31:0] run_cycles;
    logic [7:0]  mem [256];
    logic [7:0]  res [2];
    int          n_cmp, n_err;

    core_host_seq_if #(.AW(8), .DW(8)) bus ();

    core_host_seq #(
        .AW(8), .DW(8), .LOAD_BASE(LB), .LOAD_CNT(4),
        .READ_BASE(RB), .READ_CNT(2), .TMO(TMO_P)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .fin(fin), .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_dat;

    // Result words live at RB/RB+1; everything else reads the preloaded image.
    assign bus.mem_rd_dat = (bus.mem_addr == 8'(RB))     ? res[0] :
                            (bus.mem_addr == 8'(RB + 1)) ? res[1] : mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fin"}, fin, 0);
        chk({tag, "_tmo"}, timeout, 0);
        chk({tag, "_runc"}, run_cycles, 0);
        chk({tag, "_req"}, bus.core_req, 0);
        chk({tag, "_ldr"}, bus.ld_ready, 0);
        chk({tag, "_wen"}, bus.mem_wr_en, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_wdat"}, bus.mem_wr_dat, 0);
        chk({tag, "_rdv"}, bus.rd_valid, 0);
        chk({tag, "_rdd"}, bus.rd_data, 0);
    endtask

    // mode 0: done at post-request cycle dly; 1: done already high at the request;
    // 2: done never comes; 3: reset asserted mid-RUN after dly post-request cycles.
    task automatic run_seq(input int mode, input int dly);
        logic [7:0] ld_exp [4];
        int lim;
        start         = 1'b1;
        bus.core_done = (mode == 1);
        bus.rd_ready  = 1'b0;
        bus.ld_valid  = 1'b0;
        res[0]        = 8'($urandom);
        res[1]        = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_tmo_clr", timeout, 0);
        chk("load_runc_clr", run_cycles, 0);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.ld_valid = 1'b0; #1;
                chk("gap_ready", bus.ld_ready, 1);
                chk("gap_wen", bus.mem_wr_en, 0);
                @(posedge clk); #1;
            end
            bus.ld_valid = 1'b1;
            bus.ld_data  = 8'($urandom);
            ld_exp[k]    = bus.ld_data;
            #1;
            chk("ld_wen", bus.mem_wr_en, 1);
            chk("ld_addr", bus.mem_addr, 32'((LB + k) % 256));
            chk("ld_wdat", bus.mem_wr_dat, ld_exp[k]);
            chk("ld_no_rdv", bus.rd_valid, 0);
            chk("ld_no_req", bus.core_req, 0);
            @(posedge clk); #1;
        end
        bus.ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) chk("mem_img", mem[8'((LB + k) % 256)], ld_exp[k]);
        #1;
        chk("req_first", bus.core_req, 1);
        chk("req_wen", bus.mem_wr_en, 0);
        @(posedge clk); #1;
        lim = (mode == 2) ? TMO_P : dly;
        for (int j = 1; j <= lim; j++) begin
            bus.core_done = (mode < 2) && (j == dly);
            start         = (j == 1);
            #1;
            chk("run_req_low", bus.core_req, 0);
            chk("run_tmo", timeout, 0);
            chk("run_addr", bus.mem_addr, 0);
            chk("run_ldr", bus.ld_ready, 0);
            @(posedge clk); #1;
        end
        bus.core_done = 1'b0;
        start         = 1'b0;
        if (mode == 3) begin
            #1 reset = 1'b0;
            #1 chk_all_zero("rst_mid");
            repeat (3) begin
                @(posedge clk); #1;
                chk("rst_hold_fin", fin, 0);
                chk("rst_hold_busy", busy, 0);
            end
            reset = 1'b1;
            return;
        end
        chk("run_len", run_cycles, lim);
        if (mode == 2) begin
            repeat (3) begin
                chk("err_tmo", timeout, 1);
                chk("err_busy", busy, 1);
                chk("err_fin", fin, 0);
                chk("err_rdv", bus.rd_valid, 0);
                chk("err_runc", run_cycles, TMO_P);
                @(posedge clk); #1;
            end
            return;
        end
        chk("drain_fin_low", fin, 0);
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(0, 3)) begin
                bus.rd_ready = 1'b0; #1;
                chk("stall_rdv", bus.rd_valid, 1);
                chk("stall_rdd", bus.rd_data, res[i]);
                chk("stall_addr", bus.mem_addr, RB + i);
                chk("stall_ldr", bus.ld_ready, 0);
                @(posedge clk); #1;
            end
            bus.rd_ready = 1'b1; #1;
            chk("hs_rdv", bus.rd_valid, 1);
            chk("hs_rdd", bus.rd_data, res[i]);
            @(posedge clk); #1;
        end
        bus.rd_ready = 1'b0; #1;
        chk("fin_pulse", fin, 1);
        chk("fin_idle", busy, 0);
        chk("fin_rdv", bus.rd_valid, 0);
        chk("fin_runc_hold", run_cycles, lim);
        chk("fin_tmo", timeout, 0);
        @(posedge clk); #1;
        chk("fin_one_cycle", fin, 0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        start         = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 8'h00;
        bus.core_done = 1'b0;
        bus.rd_ready  = 1'b0;
        res[0]        = 8'hA5;
        res[1]        = 8'h5A;
        #1 reset = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run_seq(0, 50);
        run_seq(1, 1);
        run_seq(2, 0);
        run_seq(0, int'($urandom_range(1, 50)));
        run_seq(0, TMO_P);
        repeat (6) run_seq(0, int'($urandom_range(1, TMO_P - 1)));
        run_seq(3, int'($urandom_range(2, 20)));
        run_seq(0, int'($urandom_range(1, 50)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
